id_ex_stage: RTL
================

Name: id_ex_stage

Overview:
- Pipeline register between instruction decode and execute in the 5-stage MIPS core.
- Captures the decoder's control bundle, register operands, immediate and PC+4, and presents them registered to EX.
- Contains load-use hazard detection, which drives PC/IF-ID write enables and inserts bubbles.
- Applies branch flush and keeps saturating stall/flush event counters for the performance bench.

Parameters:
- DW, 32, datapath width of operands, immediate, PC+4
- CNT_W, 16, width of stall/flush event counters

Ports:
- clk_i  in  1  system clock, rising edge
- rst_i  in  1  asynchronous reset, active-low
- id_regwrite_i  in  1  decoder RegWrite
- id_aluop_i  in  3  decoder ALU_op
- id_alusrc_i  in  1  decoder ALUSrc
- id_regdst_i  in  1  decoder RegDst
- id_branch_i  in  1  decoder Branch
- id_memtoreg_i  in  1  decoder MemtoReg
- id_memread_i  in  1  decoder MemRead
- id_memwrite_i  in  1  decoder MemWrite
- id_rs_data_i  in  DW  register file read data rs
- id_rt_data_i  in  DW  register file read data rt
- id_imm_i  in  DW  sign-extended immediate
- id_pc4_i  in  DW  PC+4 of the ID instruction
- id_rs_i, id_rt_i, id_rd_i  in  5 each  register specifiers
- flush_i  in  1  branch taken, resolved downstream; squash the ID instruction
- ex_regwrite_o, ex_alusrc_o, ex_regdst_o, ex_branch_o, ex_memtoreg_o, ex_memread_o, ex_memwrite_o  out  1 each  registered controls
- ex_aluop_o  out  3  registered ALU_op
- ex_rs_data_o, ex_rt_data_o, ex_imm_o, ex_pc4_o  out  DW  registered data
- ex_rs_o, ex_rt_o, ex_rd_o  out  5  registered specifiers
- ex_valid_o  out  1  1 = real instruction in EX, 0 = bubble
- pc_write_o  out  1  PC enable (combinational)
- ifid_write_o  out  1  IF/ID register enable (combinational)
- stall_cnt_o, flush_cnt_o  out  CNT_W  saturating event counters

Behaviour:
- Reset (rst_i=0, async): all ex_* outputs, ex_valid_o and both counters go to 0. pc_write_o and ifid_write_o evaluate to 1, since the held EX state is a bubble.
- hazard is high when all of the following hold:
  - ex_memread_o = 1
  - ex_rt_o != 0
  - ex_rt_o == id_rs_i, or ex_rt_o == id_rt_i (both source fields always compared)
- stall = hazard & ~flush_i.
- pc_write_o = ifid_write_o = ~stall. These are purely combinational from current registers and inputs.
- Each rising edge, in priority order:
  - flush_i=1: load a bubble. All ex_* controls, data, specifiers and ex_valid_o become 0. flush_cnt_o increments.
  - else stall=1: load the same bubble. stall_cnt_o increments.
  - else: capture all id_* inputs; ex_valid_o becomes 1.
- Latency: one cycle, ID input to EX output.
- A stall lasts exactly one cycle. The bubble clears ex_memread_o, so hazard deasserts on the next cycle and the held ID instruction is then captured.
- Simultaneous flush_i and hazard: flush wins. Only flush_cnt_o increments; stall is forced low, so the PC loads the branch target.
- Counters saturate at 2^CNT_W-1 and do not wrap. Each increments by at most 1 per cycle.
- Specifier 0 never triggers a hazard, even when the load targets $0.
- Reset asserted mid-stall or mid-flush: the block returns immediately to the reset state and no partial capture occurs. Release is synchronised externally.
- Inputs are sampled only on clock edges. There is no X-propagation from unused decoder outputs, because the bubble forces zeros.

Test Plan:
- Reset, then release and feed R-type (regwrite=1, aluop=010, regdst=1, rs=1, rt=2, rd=3) -> one cycle later ex_regwrite_o=1, ex_aluop_o=010, ex_rd_o=3, ex_valid_o=1; pc_write_o=1 throughout.
- lw (memread=1, rt=8) followed by add with rs=8 -> during the add's ID cycle pc_write_o=ifid_write_o=0. Next edge: EX holds bubble (all controls 0, ex_valid_o=0) and stall_cnt_o=1. Following edge: add captured with ex_valid_o=1.
- lw rt=0 followed by add rs=0 -> no stall; stall_cnt_o stays 0.
- flush_i=1 in the same cycle lw-use hazard is present -> pc_write_o=1, bubble loaded, flush_cnt_o=1, stall_cnt_o=0.
- Force 2^CNT_W+3 consecutive flushes (CNT_W=4 override) -> flush_cnt_o holds at 15.
- Assert rst_i low between clock edges while ex_valid_o=1 -> outputs drop to 0 immediately without waiting for an edge; counters are 0.

Source files
------------

// File: rtl/id_ex_stage_if.sv
// ID/EX boundary bundle: decoder payload and flush in, registered EX payload,
// hazard enables and event counters out.
interface id_ex_stage_if #(
  parameter int unsigned DW    = 32,
  parameter int unsigned CNT_W = 16
);
  logic          id_regwrite_i;
  logic [2:0]    id_aluop_i;
  logic          id_alusrc_i;
  logic          id_regdst_i;
  logic          id_branch_i;
  logic          id_memtoreg_i;
  logic          id_memread_i;
  logic          id_memwrite_i;
  logic [DW-1:0] id_rs_data_i;
  logic [DW-1:0] id_rt_data_i;
  logic [DW-1:0] id_imm_i;
  logic [DW-1:0] id_pc4_i;
  logic [4:0]    id_rs_i;
  logic [4:0]    id_rt_i;
  logic [4:0]    id_rd_i;
  logic          flush_i;

  logic          ex_regwrite_o;
  logic [2:0]    ex_aluop_o;
  logic          ex_alusrc_o;
  logic          ex_regdst_o;
  logic          ex_branch_o;
  logic          ex_memtoreg_o;
  logic          ex_memread_o;
  logic          ex_memwrite_o;
  logic [DW-1:0] ex_rs_data_o;
  logic [DW-1:0] ex_rt_data_o;
  logic [DW-1:0] ex_imm_o;
  logic [DW-1:0] ex_pc4_o;
  logic [4:0]    ex_rs_o;
  logic [4:0]    ex_rt_o;
  logic [4:0]    ex_rd_o;
  logic          ex_valid_o;
  logic          pc_write_o;
  logic          ifid_write_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic [CNT_W-1:0] flush_cnt_o;

  modport master (
    output id_regwrite_i, id_aluop_i, id_alusrc_i, id_regdst_i, id_branch_i,
           id_memtoreg_i, id_memread_i, id_memwrite_i, id_rs_data_i, id_rt_data_i,
           id_imm_i, id_pc4_i, id_rs_i, id_rt_i, id_rd_i, flush_i,
    input  ex_regwrite_o, ex_aluop_o, ex_alusrc_o, ex_regdst_o, ex_branch_o,
           ex_memtoreg_o, ex_memread_o, ex_memwrite_o, ex_rs_data_o, ex_rt_data_o,
           ex_imm_o, ex_pc4_o, ex_rs_o, ex_rt_o, ex_rd_o, ex_valid_o,
           pc_write_o, ifid_write_o, stall_cnt_o, flush_cnt_o
  );

  modport slave (
    input  id_regwrite_i, id_aluop_i, id_alusrc_i, id_regdst_i, id_branch_i,
           id_memtoreg_i, id_memread_i, id_memwrite_i, id_rs_data_i, id_rt_data_i,
           id_imm_i, id_pc4_i, id_rs_i, id_rt_i, id_rd_i, flush_i,
    output ex_regwrite_o, ex_aluop_o, ex_alusrc_o, ex_regdst_o, ex_branch_o,
           ex_memtoreg_o, ex_memread_o, ex_memwrite_o, ex_rs_data_o, ex_rt_data_o,
           ex_imm_o, ex_pc4_o, ex_rs_o, ex_rt_o, ex_rd_o, ex_valid_o,
           pc_write_o, ifid_write_o, stall_cnt_o, flush_cnt_o
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard stall, branch flush bubble
// and saturating stall/flush event counters.
module id_ex_stage #(
  parameter int unsigned DW    = 32,
  parameter int unsigned CNT_W = 16
) (
  input logic            clk_i,
  input logic            rst_i,
  id_ex_stage_if.slave   bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef struct packed {
    logic          regwrite;
    logic [2:0]    aluop;
    logic          alusrc;
    logic          regdst;
    logic          branch;
    logic          memtoreg;
    logic          memread;
    logic          memwrite;
    logic [DW-1:0] rs_data;
    logic [DW-1:0] rt_data;
    logic [DW-1:0] imm;
    logic [DW-1:0] pc4;
    logic [4:0]    rs;
    logic [4:0]    rt;
    logic [4:0]    rd;
    logic          valid;
  } ex_t;

  ex_t              ex_q;
  ex_t              id_c;
  logic             hazard_c;
  logic             stall_c;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  // Gather the decoder payload as a valid instruction.
  always_comb begin
    id_c          = '0;
    id_c.regwrite = bus.id_regwrite_i;
    id_c.aluop    = bus.id_aluop_i;
    id_c.alusrc   = bus.id_alusrc_i;
    id_c.regdst   = bus.id_regdst_i;
    id_c.branch   = bus.id_branch_i;
    id_c.memtoreg = bus.id_memtoreg_i;
    id_c.memread  = bus.id_memread_i;
    id_c.memwrite = bus.id_memwrite_i;
    id_c.rs_data  = bus.id_rs_data_i;
    id_c.rt_data  = bus.id_rt_data_i;
    id_c.imm      = bus.id_imm_i;
    id_c.pc4      = bus.id_pc4_i;
    id_c.rs       = bus.id_rs_i;
    id_c.rt       = bus.id_rt_i;
    id_c.rd       = bus.id_rd_i;
    id_c.valid    = 1'b1;
  end

  // Load in EX whose destination is read by ID; $0 is never a real dependency.
  always_comb begin
    hazard_c = ex_q.memread && (ex_q.rt != 5'd0) &&
               ((ex_q.rt == bus.id_rs_i) || (ex_q.rt == bus.id_rt_i));
    stall_c  = hazard_c && !bus.flush_i;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ex_q <= '0;
    end else if (bus.flush_i || stall_c) begin
      ex_q <= '0;
    end else begin
      ex_q <= id_c;
    end
  end

  // Flush takes priority, so a cycle bumps at most one counter.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (bus.flush_i && (flush_cnt != CNT_MAX)) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
      if (stall_c && (stall_cnt != CNT_MAX)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.ex_regwrite_o = ex_q.regwrite;
  assign bus.ex_aluop_o    = ex_q.aluop;
  assign bus.ex_alusrc_o   = ex_q.alusrc;
  assign bus.ex_regdst_o   = ex_q.regdst;
  assign bus.ex_branch_o   = ex_q.branch;
  assign bus.ex_memtoreg_o = ex_q.memtoreg;
  assign bus.ex_memread_o  = ex_q.memread;
  assign bus.ex_memwrite_o = ex_q.memwrite;
  assign bus.ex_rs_data_o  = ex_q.rs_data;
  assign bus.ex_rt_data_o  = ex_q.rt_data;
  assign bus.ex_imm_o      = ex_q.imm;
  assign bus.ex_pc4_o      = ex_q.pc4;
  assign bus.ex_rs_o       = ex_q.rs;
  assign bus.ex_rt_o       = ex_q.rt;
  assign bus.ex_rd_o       = ex_q.rd;
  assign bus.ex_valid_o    = ex_q.valid;
  assign bus.pc_write_o    = !stall_c;
  assign bus.ifid_write_o  = !stall_c;
  assign bus.stall_cnt_o   = stall_cnt;
  assign bus.flush_cnt_o   = flush_cnt;

endmodule
